// File: rtl/gbm_tree_walker_pkg.sv
// Shared types for the decision-tree walker: node layout, FSM states.
// Node word is 64 bits spanning two 32-bit tree-memory words.
package gbm_tree_pkg;

  localparam int LEAF_BIT   = 63;
  localparam int LCHILD_HI  = 53;
  localparam int LCHILD_LO  = 43;
  localparam int FIDX_HI    = 42;
  localparam int FIDX_LO    = 32;
  localparam int THR_HI     = 31;
  localparam int THR_LO     = 0;
  localparam int NODE_WORDS = 2;
  localparam int NODE_AW    = LCHILD_HI - LCHILD_LO + 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_NODE,
    WAIT_NODE,
    FETCH_FEAT,
    WAIT_FEAT,
    DONE
  } walk_state_e;

  typedef struct packed {
    logic               leaf;
    logic [NODE_AW-1:0] lchild;
    logic [NODE_AW-1:0] fidx;
    logic [31:0]        thr;
  } node_t;

endpackage

// File: rtl/gbm_tree_walker_if.sv
// Job, tree-memory and result bundle of the tree walker.
// res_cycles exists only with GBM_WALK_CYCLE_CNT_EN.
interface gbm_tree_walker_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH_W    = 5
);

  logic                  job_valid;
  logic                  job_ready;
  logic [ADDR_WIDTH-1:0] job_root_addr;
  logic [ADDR_WIDTH-1:0] job_feat_base;

  logic                  mem_rea;
  logic [ADDR_WIDTH-1:0] mem_addr_a;
  logic [63:0]           mem_dout1;
  logic                  mem_valid1;
  logic                  mem_reb;
  logic [ADDR_WIDTH-1:0] mem_addr_b;
  logic [31:0]           mem_dout2;
  logic                  mem_valid2;

  logic                  res_valid;
  logic                  res_ready;
  logic [31:0]           res_value;
  logic [DEPTH_W-1:0]    res_depth;
  logic                  res_err;
`ifdef GBM_WALK_CYCLE_CNT_EN
  logic [15:0]           res_cycles;
`endif

  modport master (
    input  job_valid, job_root_addr, job_feat_base,
    input  mem_dout1, mem_valid1,
    input  mem_dout2, mem_valid2,
    input  res_ready,
    output job_ready,
    output mem_rea, mem_addr_a,
    output mem_reb, mem_addr_b,
    output res_valid, res_value, res_depth, res_err
`ifdef GBM_WALK_CYCLE_CNT_EN
    , output res_cycles
`endif
  );

  modport slave (
    output job_valid, job_root_addr, job_feat_base,
    output mem_dout1, mem_valid1,
    output mem_dout2, mem_valid2,
    output res_ready,
    input  job_ready,
    input  mem_rea, mem_addr_a,
    input  mem_reb, mem_addr_b,
    input  res_valid, res_value, res_depth, res_err
`ifdef GBM_WALK_CYCLE_CNT_EN
    , input res_cycles
`endif
  );

endinterface

// File: rtl/gbm_tree_walker_node_decode.sv
// Unpacks a 64-bit tree node and picks the child for a feature.
// Equal feature and threshold take the right child.
module gbm_node_decode
  import gbm_tree_pkg::*;
#(
  parameter int ADDR_WIDTH = 11
) (
  input  logic [63:0]           node_i,
  input  logic [31:0]           feat_i,
  output logic                  leaf_o,
  output logic [NODE_AW-1:0]    fidx_o,
  output logic [31:0]           thr_o,
  output logic [ADDR_WIDTH-1:0] child_o
);

  node_t                 n;
  logic [ADDR_WIDTH-1:0] left;
  logic                  unused_bits;

  assign n.leaf   = node_i[LEAF_BIT];
  assign n.lchild = node_i[LCHILD_HI:LCHILD_LO];
  assign n.fidx   = node_i[FIDX_HI:FIDX_LO];
  assign n.thr    = node_i[THR_HI:THR_LO];

  assign unused_bits = ^node_i[LEAF_BIT-1:LCHILD_HI+1];

  assign leaf_o = n.leaf;
  assign fidx_o = n.fidx;
  assign thr_o  = n.thr;
  assign left   = ADDR_WIDTH'(n.lchild);

  assign child_o = ($signed(feat_i) < $signed(n.thr))
                 ? left
                 : left + ADDR_WIDTH'(NODE_WORDS);

endmodule

// File: rtl/gbm_tree_walker.sv
// Walks one decision tree per job and returns the leaf value.
// Define GBM_WALK_CYCLE_CNT_EN to add the res_cycles latency output.
module gbm_tree_walker
  import gbm_tree_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_DEPTH  = 16,
  parameter int DEPTH_W    = 5
) (
  input logic           clk,
  input logic           rst_n,
  gbm_tree_walker_if.master bus
);

  walk_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
  logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
  logic [63:0]           node_q, node_d;
  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic                  job_ready_q, job_ready_d;
  logic                  rea_q, rea_d;
  logic                  reb_q, reb_d;
  logic                  res_valid_q, res_valid_d;
  logic                  res_err_q, res_err_d;
  logic [31:0]           res_value_q, res_value_d;
  logic [DEPTH_W-1:0]    res_depth_q, res_depth_d;

  logic [63:0]           dec_node;
  logic                  dec_leaf;
  logic [NODE_AW-1:0]    dec_fidx;
  logic [31:0]           dec_thr;
  logic [ADDR_WIDTH-1:0] dec_child;
  logic                  at_max;

  // Node fields come straight off the bus while the node lands.
  assign dec_node = (state_q == WAIT_NODE) ? bus.mem_dout1 : node_q;
  assign at_max   = (depth_q == DEPTH_W'(MAX_DEPTH));

  gbm_node_decode #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dec (
    .node_i  (dec_node),
    .feat_i  (bus.mem_dout2),
    .leaf_o  (dec_leaf),
    .fidx_o  (dec_fidx),
    .thr_o   (dec_thr),
    .child_o (dec_child)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      node_q      <= '0;
      depth_q     <= '0;
      job_ready_q <= 1'b1;
      rea_q       <= 1'b0;
      reb_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_value_q <= '0;
      res_depth_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      node_q      <= node_d;
      depth_q     <= depth_d;
      job_ready_q <= job_ready_d;
      rea_q       <= rea_d;
      reb_q       <= reb_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      res_value_q <= res_value_d;
      res_depth_q <= res_depth_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (bus.job_valid) state_d = FETCH_NODE;
      FETCH_NODE: state_d = WAIT_NODE;
      WAIT_NODE:
        if (bus.mem_valid1)
          state_d = (dec_leaf || at_max) ? DONE : FETCH_FEAT;
      FETCH_FEAT: state_d = WAIT_FEAT;
      WAIT_FEAT:  if (bus.mem_valid2) state_d = FETCH_NODE;
      DONE:       if (bus.res_ready) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    base_d      = base_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    node_d      = node_q;
    depth_d     = depth_q;
    job_ready_d = job_ready_q;
    rea_d       = 1'b0;
    reb_d       = 1'b0;
    res_valid_d = res_valid_q;
    res_err_d   = res_err_q;
    res_value_d = res_value_q;
    res_depth_d = res_depth_q;
    unique case (state_q)
      IDLE:
        if (bus.job_valid) begin
          base_d      = bus.job_feat_base;
          addr_a_d    = bus.job_root_addr;
          depth_d     = '0;
          rea_d       = 1'b1;
          job_ready_d = 1'b0;
        end
      WAIT_NODE:
        if (bus.mem_valid1) begin
          node_d = bus.mem_dout1;
          if (dec_leaf || at_max) begin
            res_valid_d = 1'b1;
            res_err_d   = !dec_leaf;
            res_value_d = dec_leaf ? dec_thr : 32'd0;
            res_depth_d = depth_q;
          end else begin
            reb_d    = 1'b1;
            addr_b_d = base_q + ADDR_WIDTH'(dec_fidx);
          end
        end
      WAIT_FEAT:
        if (bus.mem_valid2) begin
          addr_a_d = dec_child;
          depth_d  = depth_q + DEPTH_W'(1);
          rea_d    = 1'b1;
        end
      DONE:
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          job_ready_d = 1'b1;
        end
      default: ;
    endcase
  end

  assign bus.job_ready  = job_ready_q;
  assign bus.mem_rea    = rea_q;
  assign bus.mem_addr_a = addr_a_q;
  assign bus.mem_reb    = reb_q;
  assign bus.mem_addr_b = addr_b_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_value  = res_value_q;
  assign bus.res_depth  = res_depth_q;
  assign bus.res_err    = res_err_q;

`ifdef GBM_WALK_CYCLE_CNT_EN
  logic [15:0] cyc_q, cyc_d, cyc_inc;
  logic [15:0] res_cyc_q, res_cyc_d;

  // The accept cycle counts as 1; saturates at all-ones.
  assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + 16'd1;

  always_comb begin
    cyc_d     = cyc_q;
    res_cyc_d = res_cyc_q;
    unique case (state_q)
      IDLE:    if (bus.job_valid) cyc_d = 16'd1;
      FETCH_NODE, WAIT_NODE,
      FETCH_FEAT, WAIT_FEAT:
               cyc_d = cyc_inc;
      default: ;
    endcase
    if (state_q == WAIT_NODE && state_d == DONE)
      res_cyc_d = cyc_inc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q     <= '0;
      res_cyc_q <= '0;
    end else begin
      cyc_q     <= cyc_d;
      res_cyc_q <= res_cyc_d;
    end
  end

  assign bus.res_cycles = res_cyc_q;
`endif

endmodule

// File: tb/tb_gbm_tree_walker.sv
// Directed bench for gbm_tree_walker with a latency-configurable memory model.
// Vector table plus backpressure, address-log and mid-walk reset sequences.
module tb_gbm_tree_walker;

  localparam int AW = 11;
  localparam int DW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gbm_tree_walker_if #(.ADDR_WIDTH(AW), .DEPTH_W(DW)) bus ();

  gbm_tree_walker #(
    .ADDR_WIDTH (AW),
    .MAX_DEPTH  (16),
    .DEPTH_W    (DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory model: nodes and feature words, one read outstanding.
  logic [63:0] node_mem [0:2047];
  logic [31:0] word_mem [0:2047];
  int          lat_min = 2;
  int          lat_max = 2;
  bit          spur = 1'b0;
  int          viol = 0;
  int          cnt1 = 0;
  int          cnt2 = 0;
  logic [AW-1:0] a1, a2;
  logic [AW-1:0] blog [$];

  initial begin
    bus.mem_valid1 = 1'b0;
    bus.mem_valid2 = 1'b0;
    bus.mem_dout1  = '0;
    bus.mem_dout2  = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_valid1 = 1'b0;
      bus.mem_valid2 = 1'b0;
      if (cnt1 > 0) begin
        cnt1--;
        if (cnt1 == 0) begin
          bus.mem_valid1 = 1'b1;
          bus.mem_dout1  = node_mem[a1];
        end
      end
      if (cnt2 > 0) begin
        cnt2--;
        if (cnt2 == 0) begin
          bus.mem_valid2 = 1'b1;
          bus.mem_dout2  = word_mem[a2];
        end
      end
      if (bus.mem_rea && bus.mem_reb) viol++;
      if ((bus.mem_rea || bus.mem_reb) && (cnt1 != 0 || cnt2 != 0))
        viol++;
      if (bus.mem_rea) begin
        cnt1 = $urandom_range(lat_max, lat_min);
        a1   = bus.mem_addr_a;
      end
      if (bus.mem_reb) begin
        cnt2 = $urandom_range(lat_max, lat_min);
        a2   = bus.mem_addr_b;
        blog.push_back(bus.mem_addr_b);
      end
      if (spur && (bus.mem_rea || bus.mem_reb)) begin
        bus.mem_valid1 = 1'b1;
        bus.mem_valid2 = 1'b1;
        bus.mem_dout1  = {$urandom, $urandom};
        bus.mem_dout2  = $urandom;
      end
    end
  end

  function automatic logic [63:0] nd_int(input logic [10:0] left,
                                         input logic [10:0] fidx,
                                         input logic [31:0] thr);
    return {1'b0, 9'd0, left, fidx, thr};
  endfunction

  function automatic logic [63:0] nd_leaf(input logic [31:0] v);
    return {1'b1, 31'd0, v};
  endfunction

  typedef struct {
    logic [AW-1:0] root;
    logic [AW-1:0] base;
    logic [31:0]   val;
    int            depth;
    bit            err;
    int            cyc;
  } vec_t;

  vec_t vt [10];

  task automatic start_job(input logic [AW-1:0] root,
                           input logic [AW-1:0] base);
    int n;
    n = 0;
    bus.job_valid     = 1'b1;
    bus.job_root_addr = root;
    bus.job_feat_base = base;
    while (!bus.job_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.job_ready) chk("job_ready timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.job_valid = 1'b0;
  endtask

  task automatic wait_res(output int cyc);
    cyc = 1;
    while (!bus.res_valid && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!bus.res_valid) chk("res_valid timeout", 64'd0, 64'd1);
  endtask

  task automatic run_vec(input int i, input bit chk_cyc);
    int cyc;
    start_job(vt[i].root, vt[i].base);
    wait_res(cyc);
    chk($sformatf("v%0d value", i), 64'(bus.res_value), 64'(vt[i].val));
    chk($sformatf("v%0d depth", i), 64'(bus.res_depth), 64'(vt[i].depth));
    chk($sformatf("v%0d err", i), 64'(bus.res_err), 64'(vt[i].err));
    if (chk_cyc) begin
      chk($sformatf("v%0d latency", i), 64'(cyc), 64'(vt[i].cyc));
`ifdef GBM_WALK_CYCLE_CNT_EN
      chk($sformatf("v%0d res_cycles", i), 64'(bus.res_cycles),
          64'(vt[i].cyc));
`endif
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d handshake", i),
        64'({bus.res_valid, bus.job_ready}), 64'(2'b01));
  endtask

  initial begin
    int cyc;
    int n;
    bus.job_valid     = 1'b0;
    bus.job_root_addr = '0;
    bus.job_feat_base = '0;
    bus.res_ready     = 1'b1;

    for (int i = 0; i < 2048; i++) begin
      node_mem[i] = nd_leaf(32'hDEAD_0000 + 32'(i));
      word_mem[i] = 32'd0;
    end
    node_mem[0]    = nd_int(11'd2, 11'd3, 32'd100);
    node_mem[2]    = nd_leaf(32'h0000_BAD0);
    node_mem[4]    = nd_int(11'd6, 11'd1, 32'hFFFF_FFFB);
    node_mem[6]    = nd_leaf(32'h0000_BAD1);
    node_mem[8]    = nd_leaf(32'd77);
    node_mem[20]   = nd_leaf(32'h0000_1234);
    node_mem[30]   = nd_int(11'd40, 11'd0, 32'd10);
    node_mem[40]   = nd_leaf(32'h0000_AAAA);
    node_mem[42]   = nd_leaf(32'h0000_BBBB);
    node_mem[2046] = nd_int(11'd2047, 11'd5, 32'd0);
    node_mem[2047] = nd_leaf(32'h0000_BAD2);
    node_mem[1]    = nd_leaf(32'h0000_0055);
    node_mem[100]  = nd_int(11'd100, 11'd0, 32'd1000);
    word_mem[67]   = 32'd150;
    word_mem[65]   = 32'hFFFF_FFFB;
    word_mem[128]  = 32'd3;
    word_mem[132]  = 32'd10;
    word_mem[136]  = 32'hFFFF_FF9C;
    word_mem[140]  = 32'h8000_0000;
    word_mem[144]  = 32'h7FFF_FFFF;
    word_mem[2]    = 32'd1;
    word_mem[200]  = 32'd5;

    vt[0] = '{11'd20,   11'd0,    32'h1234, 0,  1'b0, 4};
    vt[1] = '{11'd0,    11'd64,   32'd77,   2,  1'b0, 16};
    vt[2] = '{11'd30,   11'd128,  32'hAAAA, 1,  1'b0, 10};
    vt[3] = '{11'd30,   11'd132,  32'hBBBB, 1,  1'b0, 10};
    vt[4] = '{11'd30,   11'd136,  32'hAAAA, 1,  1'b0, 10};
    vt[5] = '{11'd30,   11'd140,  32'hAAAA, 1,  1'b0, 10};
    vt[6] = '{11'd30,   11'd144,  32'hBBBB, 1,  1'b0, 10};
    vt[7] = '{11'd2046, 11'd2045, 32'h55,   1,  1'b0, 10};
    vt[8] = '{11'd100,  11'd200,  32'd0,    16, 1'b1, 100};
    vt[9] = '{11'd20,   11'd0,    32'h1234, 0,  1'b0, 4};

    repeat (3) @(posedge clk);
    #1;
    chk("reset state",
        {bus.job_ready, bus.mem_rea, bus.mem_reb, bus.res_valid,
         bus.res_err, bus.res_value, bus.res_depth,
         bus.mem_addr_a, bus.mem_addr_b},
        {1'b1, 4'b0, 32'd0, 5'd0, 11'd0, 11'd0});
`ifdef GBM_WALK_CYCLE_CNT_EN
    chk("reset res_cycles", 64'(bus.res_cycles), 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec(i, 1'b1);

    blog.delete();
    run_vec(1, 1'b1);
    chk("addr_b count", 64'(blog.size()), 64'd2);
    chk("addr_b first", 64'(blog.size() > 0 ? blog[0] : 11'h7FF), 64'd67);
    chk("addr_b second", 64'(blog.size() > 1 ? blog[1] : 11'h7FF), 64'd65);

    lat_min = 2;
    lat_max = 8;
    spur    = 1'b1;
    for (int i = 0; i < 10; i++) run_vec(i, 1'b0);
    spur    = 1'b0;
    lat_max = 2;

    bus.res_ready = 1'b0;
    start_job(11'd20, 11'd0);
    wait_res(cyc);
    chk("bp value", 64'(bus.res_value), 64'h1234);
    bus.job_valid     = 1'b1;
    bus.job_root_addr = 11'd30;
    bus.job_feat_base = 11'd128;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold %0d", i),
          {bus.res_valid, bus.job_ready, bus.mem_rea, bus.res_value},
          {1'b1, 1'b0, 1'b0, 32'h1234});
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release idle", 64'({bus.job_ready, bus.res_valid}), 64'(2'b10));
    @(posedge clk); #1;
    chk("bp next accept", {bus.job_ready, bus.mem_rea, bus.mem_addr_a},
        {1'b0, 1'b1, 11'd30});
    bus.job_valid = 1'b0;
    wait_res(cyc);
    chk("bp next value", 64'(bus.res_value), 64'hAAAA);
    chk("bp next latency", 64'(cyc), 64'd10);
    @(posedge clk); #1;

    lat_min = 6;
    lat_max = 6;
    start_job(11'd30, 11'd128);
    n = 0;
    while (!bus.mem_reb && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst reb seen", 64'(bus.mem_reb), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst idle",
        64'({bus.job_ready, bus.res_valid, bus.mem_rea, bus.mem_reb}),
        64'(4'b1000));
    rst_n   = 1'b1;
    lat_min = 2;
    lat_max = 2;
    repeat (10) @(posedge clk);
    #1;
    chk("rst late valid ignored",
        64'({bus.job_ready, bus.res_valid, bus.mem_rea}), 64'(3'b100));
    run_vec(0, 1'b1);

    chk("strobe overlap", 64'(viol), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
